reg_file_arbiter: RTL and testbench
===================================

Name: reg_file_arbiter

Overview:
- Shares the single-port 8x16 register file (one command per cycle via WrEn/RdEn/Address/WrData; RdData registered) between two requesters.
- Round-robin arbitration with a per-requester req/ack handshake.
- Sequences each access: issue strobe, then capture read data, then acknowledge.
- Sits between two masters (e.g. a control FSM and a debug port) and the register file instance.

Parameters:
- DATA_WIDTH, 16, register file data width.
- ADDR_WIDTH, 3, register file address width (2**ADDR_WIDTH entries).

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous active-high reset.
- Req0  input  1  requester 0 access request; held high with stable command until Ack0.
- We0  input  1  requester 0 command: 1 = write, 0 = read.
- Addr0  input  ADDR_WIDTH  requester 0 register address.
- WrData0  input  DATA_WIDTH  requester 0 write data.
- Ack0  output  1  one-cycle completion pulse to requester 0.
- RdData0  output  DATA_WIDTH  requester 0 read result; valid while Ack0=1, held until next requester 0 read completes.
- Req1/We1/Addr1/WrData1/Ack1/RdData1  same as requester 0, for requester 1.
- Rf_WrEn  output  1  register file write enable.
- Rf_RdEn  output  1  register file read enable.
- Rf_Address  output  ADDR_WIDTH  register file address.
- Rf_WrData  output  DATA_WIDTH  register file write data.
- Rf_RdData  input  DATA_WIDTH  register file read data, valid the cycle after Rf_RdEn is sampled.
- Busy  output  1  high in every state except IDLE.

Behaviour:
- All outputs are registered.
- Reset (async, RST=1):
  - State = IDLE.
  - Ack0/Ack1, Rf_WrEn, Rf_RdEn, Busy = 0.
  - Rf_Address, Rf_WrData, RdData0, RdData1 = 0.
  - Priority pointer = requester 0.
- Reset mid-operation aborts the access with no further strobe and no Ack. A write already strobed remains in the register file.
- States: IDLE -> ISSUE -> CAPTURE -> DONE -> IDLE. There is no other path.
- IDLE:
  - If neither Req is high, stay in IDLE.
  - If exactly one Req is high, grant it.
  - If both are high, grant the requester indicated by the pointer.
  - On grant: latch We/Addr/WrData of the winner into Rf_Address/Rf_WrData, record the winner, flip the pointer to the other requester, and go to ISSUE.
- ISSUE: exactly one of Rf_WrEn/Rf_RdEn is high for exactly one cycle, per the latched We. Go to CAPTURE.
- CAPTURE:
  - Strobes are low.
  - For a read, Rf_RdData is sampled at the end of this cycle into RdData of the winner.
  - Set Ack of the winner. Go to DONE.
- DONE: Ack of the winner is high for this cycle only. Go to IDLE.
- Latency: a Req sampled in IDLE at edge N gives strobe high in cycle N+1 and Ack high in cycle N+3. Throughput is one access per 4 cycles.
- Requesters must deassert Req (or present a new command) in the cycle after Ack. A Req still high in IDLE is a new request.
- Rf_WrEn and Rf_RdEn are never high simultaneously.
- Rf_Address and Rf_WrData hold their last values between accesses.
- The non-granted requester's Req/We/Addr/WrData are ignored until IDLE. A request arriving mid-access waits.
- Pointer updates only on grant. A lone requester can be served back-to-back. When both request continuously, grants strictly alternate.
- Writes leave RdData unchanged.
- Ack0 and Ack1 are never high in the same cycle.

Test Plan:
- Reset, then Req0 write Addr0=3'd0, WrData0=16'h0001 -> Rf_WrEn=1, Rf_Address=0, Rf_WrData=16'h0001 one cycle after the IDLE sample edge; Ack0 pulses 2 cycles later; Rf_RdEn stays 0.
- Req1 read Addr1=3'd0 after the first test -> Rf_RdEn single-cycle pulse; RdData1=16'h0001 with Ack1 at grant+3 cycles; RdData0 unchanged.
- Req0 writes 3'd1=16'h0002 and Req1 writes 3'd2=16'h0003 in the same cycle after reset -> requester 0 is served first, requester 1 next, Acks 4 cycles apart; readback gives 16'h0002 and 16'h0003.
- Both requesters read continuously for 6 grants -> grant order 0,1,0,1,0,1; never two Acks together; never both Rf strobes high.
- RST asserted during CAPTURE of a read -> outputs clear immediately, no Ack, Busy=0; after release, a pending Req0 is served normally.
- Req0 held high through Ack0 with a new read command -> second access starts at the IDLE cycle after DONE with its own Ack.

Source files
------------

// File: rtl/reg_file_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_arbiter
// Purpose  : Shares one single-port register file between two requesters.
//            Round-robin arbitration with a req/ack handshake per requester.
//            Each access walks IDLE -> ISSUE -> CAPTURE -> DONE: the command
//            is latched on grant, one strobe cycle is issued, read data is
//            captured one cycle later, and a one-cycle Ack is returned.
// Ports    : CLK, RST            clock (rising edge), async active-high reset
//            Req/We/Addr/WrData  requester 0/1 command inputs
//            Ack0/1, RdData0/1   requester 0/1 completion pulse and read data
//            Rf_WrEn/Rf_RdEn/Rf_Address/Rf_WrData  register file command
//            Rf_RdData           register file read data (one cycle latency)
//            Busy                high whenever the sequencer is not idle
// Revision : 1.0  initial release
// ============================================================================
module reg_file_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Req0,
  input  logic                  We0,
  input  logic [ADDR_WIDTH-1:0] Addr0,
  input  logic [DATA_WIDTH-1:0] WrData0,
  output logic                  Ack0,
  output logic [DATA_WIDTH-1:0] RdData0,
  input  logic                  Req1,
  input  logic                  We1,
  input  logic [ADDR_WIDTH-1:0] Addr1,
  input  logic [DATA_WIDTH-1:0] WrData1,
  output logic                  Ack1,
  output logic [DATA_WIDTH-1:0] RdData1,
  output logic                  Rf_WrEn,
  output logic                  Rf_RdEn,
  output logic [ADDR_WIDTH-1:0] Rf_Address,
  output logic [DATA_WIDTH-1:0] Rf_WrData,
  input  logic [DATA_WIDTH-1:0] Rf_RdData,
  output logic                  Busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t state, state_next;

  // owner: requester currently being served; ptr: requester that wins a tie
  logic owner, owner_next;
  logic ptr, ptr_next;
  logic we_lat, we_next;
  logic grant;

  logic                  ack0_next, ack1_next;
  logic                  wren_next, rden_next;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic [DATA_WIDTH-1:0] wdata_next;
  logic [DATA_WIDTH-1:0] rd0_next, rd1_next;
  logic                  busy_next;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      owner      <= 1'b0;
      ptr        <= 1'b0;
      we_lat     <= 1'b0;
      Ack0       <= 1'b0;
      Ack1       <= 1'b0;
      Rf_WrEn    <= 1'b0;
      Rf_RdEn    <= 1'b0;
      Rf_Address <= '0;
      Rf_WrData  <= '0;
      RdData0    <= '0;
      RdData1    <= '0;
      Busy       <= 1'b0;
    end else begin
      state      <= state_next;
      owner      <= owner_next;
      ptr        <= ptr_next;
      we_lat     <= we_next;
      Ack0       <= ack0_next;
      Ack1       <= ack1_next;
      Rf_WrEn    <= wren_next;
      Rf_RdEn    <= rden_next;
      Rf_Address <= addr_next;
      Rf_WrData  <= wdata_next;
      RdData0    <= rd0_next;
      RdData1    <= rd1_next;
      Busy       <= busy_next;
    end
  end

  // Every output is registered, so each value below is what the output
  // shows during the cycle spent in state_next.
  always_comb begin
    state_next = state;
    owner_next = owner;
    ptr_next   = ptr;
    we_next    = we_lat;
    grant      = 1'b0;
    ack0_next  = 1'b0;
    ack1_next  = 1'b0;
    wren_next  = 1'b0;
    rden_next  = 1'b0;
    addr_next  = Rf_Address;
    wdata_next = Rf_WrData;
    rd0_next   = RdData0;
    rd1_next   = RdData1;

    case (state)
      IDLE: begin
        if (Req0 || Req1) begin
          // Tie goes to the pointer; a lone requester always wins.
          grant      = (Req0 && Req1) ? ptr : Req1;
          owner_next = grant;
          ptr_next   = ~grant;
          we_next    = grant ? We1 : We0;
          addr_next  = grant ? Addr1 : Addr0;
          wdata_next = grant ? WrData1 : WrData0;
          // Strobe is raised on entry to ISSUE.
          wren_next  = we_next;
          rden_next  = ~we_next;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        state_next = CAPTURE;
      end
      CAPTURE: begin
        // Rf_RdData now reflects the read strobed during ISSUE.
        if (!we_lat) begin
          if (owner) rd1_next = Rf_RdData;
          else       rd0_next = Rf_RdData;
        end
        ack0_next  = ~owner;
        ack1_next  = owner;
        state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_arbiter
// Purpose  : Self-checking bench for reg_file_arbiter. A transaction-level
//            model predicts grants, strobes, acks and read data; a monitor
//            compares the DUT against the predicted queues every cycle.
// Revision : 1.0  initial release
// ============================================================================
module tb_reg_file_arbiter;

  logic        CLK, RST;
  logic        Req0, We0, Req1, We1;
  logic [2:0]  Addr0, Addr1;
  logic [15:0] WrData0, WrData1;
  logic        Ack0, Ack1, Rf_WrEn, Rf_RdEn, Busy;
  logic [15:0] RdData0, RdData1, Rf_WrData;
  logic [15:0] Rf_RdData;
  logic [2:0]  Rf_Address;

  reg_file_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) dut (
    .CLK(CLK), .RST(RST),
    .Req0(Req0), .We0(We0), .Addr0(Addr0), .WrData0(WrData0),
    .Ack0(Ack0), .RdData0(RdData0),
    .Req1(Req1), .We1(We1), .Addr1(Addr1), .WrData1(WrData1),
    .Ack1(Ack1), .RdData1(RdData1),
    .Rf_WrEn(Rf_WrEn), .Rf_RdEn(Rf_RdEn), .Rf_Address(Rf_Address),
    .Rf_WrData(Rf_WrData), .Rf_RdData(Rf_RdData), .Busy(Busy)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Behavioural register file: read data appears the cycle after Rf_RdEn.
  logic [15:0] rf_mem [8] = '{default: 16'h0000};
  always @(posedge CLK) begin
    if (Rf_WrEn) rf_mem[Rf_Address] <= Rf_WrData;
    if (Rf_RdEn) Rf_RdData <= rf_mem[Rf_Address];
  end

  typedef struct {
    int          edge_n;
    bit          who;
    bit          we;
    logic [2:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } rec_t;

  typedef struct {
    bit          we;
    logic [2:0]  addr;
    logic [15:0] data;
  } cmd_t;

  int chk = 0;
  int err = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          edge_cnt   = 0;
  int          next_grant = 0;
  int          busy_until = -1;
  bit          ptr_m      = 1'b0;
  logic [15:0] mem_m [8]  = '{default: 16'h0000};
  logic [15:0] exp_rd [2] = '{16'h0, 16'h0};
  logic [2:0]  exp_addr   = 3'd0;
  logic [15:0] exp_wdata  = 16'h0;
  rec_t        strobe_q[$];
  rec_t        ack_q[$];
  bit          grant_who[$];
  int          grant_edge[$];

  // One access per four edges; grant on the first eligible edge with a Req.
  initial begin
    rec_t r;
    bit   w;
    forever begin
      @(posedge CLK);
      edge_cnt++;
      if (!RST && edge_cnt >= next_grant && (Req0 || Req1)) begin
        w       = (Req0 && Req1) ? ptr_m : Req1;
        ptr_m   = !w;
        r.who   = w;
        r.we    = w ? We1 : We0;
        r.addr  = w ? Addr1 : Addr0;
        r.wdata = w ? WrData1 : WrData0;
        r.rdata = mem_m[r.addr];
        if (r.we) mem_m[r.addr] = r.wdata;
        r.edge_n = edge_cnt;
        strobe_q.push_back(r);
        r.edge_n = edge_cnt + 2;
        ack_q.push_back(r);
        busy_until = edge_cnt + 2;
        next_grant = edge_cnt + 4;
      end
    end
  end

  task automatic model_reset();
    strobe_q.delete();
    ack_q.delete();
    next_grant = 0;
    busy_until = -1;
    ptr_m      = 1'b0;
    exp_rd[0]  = 16'h0;
    exp_rd[1]  = 16'h0;
    exp_addr   = 3'd0;
    exp_wdata  = 16'h0;
  endtask

  // ---------------- monitor ----------------
  initial begin
    rec_t r;
    int   last;
    forever begin
      @(negedge CLK);
      last = edge_cnt;
      check("no_dual_strobe", {31'd0, Rf_WrEn & Rf_RdEn}, 32'd0);
      check("no_dual_ack", {31'd0, Ack0 & Ack1}, 32'd0);
      if (strobe_q.size() > 0 && strobe_q[0].edge_n == last) begin
        r = strobe_q.pop_front();
        check("strobe_wr", {31'd0, Rf_WrEn}, {31'd0, r.we});
        check("strobe_rd", {31'd0, Rf_RdEn}, {31'd0, !r.we});
        exp_addr  = r.addr;
        exp_wdata = r.wdata;
      end else begin
        check("strobe_idle", {30'd0, Rf_WrEn, Rf_RdEn}, 32'd0);
      end
      check("rf_address", {29'd0, Rf_Address}, {29'd0, exp_addr});
      check("rf_wrdata", {16'd0, Rf_WrData}, {16'd0, exp_wdata});
      if (ack_q.size() > 0 && ack_q[0].edge_n == last) begin
        r = ack_q.pop_front();
        check("ack_who", {30'd0, Ack1, Ack0}, r.who ? 32'd2 : 32'd1);
        if (!r.we) exp_rd[r.who] = r.rdata;
        grant_who.push_back(r.who);
        grant_edge.push_back(last);
      end else begin
        check("ack_idle", {30'd0, Ack1, Ack0}, 32'd0);
      end
      check("rddata0", {16'd0, RdData0}, {16'd0, exp_rd[0]});
      check("rddata1", {16'd0, RdData1}, {16'd0, exp_rd[1]});
      check("busy", {31'd0, Busy}, {31'd0, last <= busy_until});
    end
  end

  // ---------------- requester drivers ----------------
  cmd_t q0[$];
  cmd_t q1[$];
  bit   act0 = 0, act1 = 0;
  int   tmo0 = 0, tmo1 = 0;

  initial begin
    cmd_t c;
    Req0 = 0; We0 = 0; Addr0 = 0; WrData0 = 0;
    Req1 = 0; We1 = 0; Addr1 = 0; WrData1 = 0;
    forever begin
      @(negedge CLK);
      // requester 0
      if (act0 && Ack0) begin
        if (q0.size() > 0) begin
          c = q0.pop_front();
          We0 = c.we; Addr0 = c.addr; WrData0 = c.data; tmo0 = 0;
        end else begin
          Req0 = 0; act0 = 0;
          Addr0 = 3'($urandom_range(0, 7)); WrData0 = 16'($urandom);
        end
      end else if (!act0 && q0.size() > 0) begin
        c = q0.pop_front();
        Req0 = 1; We0 = c.we; Addr0 = c.addr; WrData0 = c.data;
        act0 = 1; tmo0 = 0;
      end else if (act0) begin
        tmo0++;
        if (tmo0 > 40) begin
          chk++; err++;
          $display("FAIL ack0_timeout: got no Ack0 expected Ack0 within 40 cycles");
          Req0 = 0; act0 = 0;
        end
      end
      // requester 1
      if (act1 && Ack1) begin
        if (q1.size() > 0) begin
          c = q1.pop_front();
          We1 = c.we; Addr1 = c.addr; WrData1 = c.data; tmo1 = 0;
        end else begin
          Req1 = 0; act1 = 0;
          Addr1 = 3'($urandom_range(0, 7)); WrData1 = 16'($urandom);
        end
      end else if (!act1 && q1.size() > 0) begin
        c = q1.pop_front();
        Req1 = 1; We1 = c.we; Addr1 = c.addr; WrData1 = c.data;
        act1 = 1; tmo1 = 0;
      end else if (act1) begin
        tmo1++;
        if (tmo1 > 40) begin
          chk++; err++;
          $display("FAIL ack1_timeout: got no Ack1 expected Ack1 within 40 cycles");
          Req1 = 0; act1 = 0;
        end
      end
    end
  end

  function automatic cmd_t mk(bit we, logic [2:0] a, logic [15:0] d);
    cmd_t c;
    c.we = we; c.addr = a; c.data = d;
    return c;
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || act0 || act1 || ack_q.size() > 0)
           && n < 400) begin
      @(negedge CLK);
      n++;
    end
    chk++;
    if (n >= 400) begin
      err++;
      $display("FAIL drain_timeout: got pending traffic expected idle after 400 cycles");
    end
    repeat (2) @(negedge CLK);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int sz;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    #1 RST = 1'b0;

    // lone write, then lone read of the same address by the other requester
    q0.push_back(mk(1, 3'd0, 16'h0001));
    wait_idle();
    q1.push_back(mk(0, 3'd0, 16'hdead));
    wait_idle();
    check("read_after_write", {16'd0, RdData1}, 32'h0001);
    check("rd0_untouched", {16'd0, RdData0}, 32'h0000);

    // simultaneous writes, then readback
    q0.push_back(mk(1, 3'd1, 16'h0002));
    q1.push_back(mk(1, 3'd2, 16'h0003));
    wait_idle();
    q0.push_back(mk(0, 3'd1, 16'h0));
    q1.push_back(mk(0, 3'd2, 16'h0));
    wait_idle();
    check("readback0", {16'd0, RdData0}, 32'h0002);
    check("readback1", {16'd0, RdData1}, 32'h0003);
    sz = grant_who.size();
    check("tie_order_a", {31'd0, grant_who[sz-4]}, 32'd0);
    check("tie_order_b", {31'd0, grant_who[sz-3]}, 32'd1);
    check("tie_gap", grant_edge[sz-3] - grant_edge[sz-4], 32'd4);

    // continuous contention: grants must alternate
    for (int i = 0; i < 3; i++) begin
      q0.push_back(mk(0, 3'(i), 16'h0));
      q1.push_back(mk(0, 3'(i + 1), 16'h0));
    end
    wait_idle();
    sz = grant_who.size();
    for (int i = 0; i < 6; i++)
      check("alternate", {31'd0, grant_who[sz-6+i]}, 32'(i % 2));

    // reset during CAPTURE of a read; pending Req0 is served afterwards
    q0.push_back(mk(0, 3'd1, 16'h0));
    n = 0;
    while (!Rf_RdEn && n < 20) begin
      @(negedge CLK);
      n++;
    end
    check("saw_rden", {31'd0, Rf_RdEn}, 32'd1);
    @(negedge CLK);
    #1 RST = 1'b1;
    model_reset();
    #1;
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_ack", {30'd0, Ack1, Ack0}, 32'd0);
    check("rst_addr", {29'd0, Rf_Address}, 32'd0);
    check("rst_rd", {16'd0, RdData0}, 32'd0);
    repeat (2) @(negedge CLK);
    #1 RST = 1'b0;
    wait_idle();
    check("after_rst_read", {16'd0, RdData0}, 32'h0002);

    // Req0 held through Ack0 with a new command: back-to-back service
    q0.push_back(mk(0, 3'd2, 16'h0));
    q0.push_back(mk(0, 3'd0, 16'h0));
    wait_idle();
    sz = grant_edge.size();
    check("b2b_gap", grant_edge[sz-1] - grant_edge[sz-2], 32'd4);
    check("b2b_data", {16'd0, RdData0}, 32'h0001);

    // randomized traffic
    for (int i = 0; i < 150; i++) begin
      @(negedge CLK);
      if ($urandom_range(0, 2) == 0 && q0.size() < 2)
        q0.push_back(mk(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom)));
      if ($urandom_range(0, 2) == 0 && q1.size() < 2)
        q1.push_back(mk(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom)));
    end
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule
`default_nettype wire
